// File: rtl/lcd_msg_ctrl.sv
// HD44780 message controller: init, clear, per-line address set and character writes from an external ROM.
// Each LCD transaction runs as SETUP / STROBE / HOLD phases, plus an extra wait after the clear command.
//
//   state     | meaning
//   WAIT_RDY  | idle after reset until ready_i
//   INIT      | function set, entry mode, display on
//   CLEAR     | clear display, latch requested message
//   ADDR      | set DDRAM address for current line
//   CHARS     | write COLS characters of current line
//   SHOW      | message displayed, watch sleep/select/refresh
//   OFF_CMD   | display-off command
//   OFF       | display off, wait for wake
//   WAKE      | display-on command, then full rewrite
module lcd_msg_ctrl #(
   parameter int NUM_MSG         = 4,
   parameter int LINES           = 2,
   parameter int COLS            = 16,
   parameter int TICK_CYCLES     = 800000,
   parameter int CLR_WAIT_CYCLES = 100000,
   parameter int SEL_W           = (NUM_MSG > 1) ? $clog2(NUM_MSG) : 1,
   parameter int ADDR_W          = (NUM_MSG*LINES*COLS > 1) ? $clog2(NUM_MSG*LINES*COLS) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ready_i,
   input  logic              sleep_i,
   input  logic [SEL_W-1:0]  msg_sel,
   input  logic              refresh_i,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [7:0]        rom_data,
   output logic              rs,
   output logic              rw,
   output logic              en,
   output logic [7:0]        dat,
   output logic              busy,
   output logic              done
);

   localparam int CNT_MAX = (TICK_CYCLES > CLR_WAIT_CYCLES) ? TICK_CYCLES : CLR_WAIT_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;
   localparam int LINE_W  = (LINES > 1) ? $clog2(LINES) : 1;
   localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(COLS - 1);
   localparam logic [LINE_W-1:0] LINE_LAST = LINE_W'(LINES - 1);
   localparam logic [CNT_W-1:0]  TICK_LD   = CNT_W'(TICK_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CLR_LD    = CNT_W'(CLR_WAIT_CYCLES - 1);

   typedef enum logic [3:0] {
      S_WAIT_RDY, S_INIT, S_CLEAR, S_ADDR, S_CHARS, S_SHOW, S_OFF_CMD, S_OFF, S_WAKE
   } state_t;

   typedef enum logic [2:0] {P_IDLE, P_SETUP, P_STROBE, P_HOLD, P_CWAIT} phase_t;

   state_t            state, nxt_state;
   phase_t            ph;
   logic [CNT_W-1:0]  cnt;
   logic [1:0]        init_idx, nxt_idx;
   logic [COL_W-1:0]  col, nxt_col;
   logic [LINE_W-1:0] line, nxt_line;
   logic [SEL_W-1:0]  sel_q;
   logic              is_clr;
   logic              tx_end, ev, launch, fin_msg, l_rs;
   logic [7:0]        l_cmd;
   logic [ADDR_W-1:0] l_addr;

   assign rw     = 1'b0;
   assign tx_end = ((ph == P_HOLD) && (cnt == '0) && !is_clr) || ((ph == P_CWAIT) && (cnt == '0));

   // Decide what follows the current state/transaction and what the next transaction carries,
   // so back-to-back transactions start without a gap cycle.
   always_comb begin
      nxt_state = state;
      nxt_idx   = init_idx;
      nxt_col   = col;
      nxt_line  = line;
      ev        = 1'b0;
      fin_msg   = 1'b0;
      case (state)
         S_WAIT_RDY: if (ready_i) begin
            ev = 1'b1; nxt_state = S_INIT; nxt_idx = 2'd0;
         end
         S_INIT: if (tx_end) begin
            ev = 1'b1;
            if (init_idx == 2'd2) begin
               nxt_state = S_CLEAR; nxt_col = '0; nxt_line = '0;
            end else begin
               nxt_idx = init_idx + 2'd1;
            end
         end
         S_CLEAR: if (tx_end) begin
            ev = 1'b1; nxt_state = S_ADDR;
         end
         S_ADDR: if (tx_end) begin
            ev = 1'b1; nxt_state = S_CHARS; nxt_col = '0;
         end
         S_CHARS: if (tx_end) begin
            ev = 1'b1;
            if (col == COL_LAST) begin
               nxt_col = '0;
               if (line == LINE_LAST) begin
                  nxt_state = S_SHOW; fin_msg = 1'b1;
               end else begin
                  nxt_state = S_ADDR; nxt_line = line + 1'b1;
               end
            end else begin
               nxt_col = col + 1'b1;
            end
         end
         S_SHOW: if (sleep_i) begin
            ev = 1'b1; nxt_state = S_OFF_CMD;
         end else if ((msg_sel != sel_q) || refresh_i) begin
            ev = 1'b1; nxt_state = S_CLEAR; nxt_col = '0; nxt_line = '0;
         end
         S_OFF_CMD: if (tx_end) begin
            ev = 1'b1; nxt_state = S_OFF;
         end
         S_OFF: if (!sleep_i) begin
            ev = 1'b1; nxt_state = S_WAKE;
         end
         S_WAKE: if (tx_end) begin
            ev = 1'b1; nxt_state = S_CLEAR; nxt_col = '0; nxt_line = '0;
         end
         default: begin
            ev = 1'b1; nxt_state = S_WAIT_RDY;
         end
      endcase

      launch = ev && (nxt_state != S_WAIT_RDY) && (nxt_state != S_SHOW) && (nxt_state != S_OFF);
      l_rs   = (nxt_state == S_CHARS);
      case (nxt_state)
         S_INIT:    l_cmd = (nxt_idx == 2'd0) ? 8'h38 : (nxt_idx == 2'd1) ? 8'h06 : 8'h0C;
         S_CLEAR:   l_cmd = 8'h01;
         S_ADDR:    l_cmd = (nxt_line != '0) ? 8'hC0 : 8'h80;
         S_OFF_CMD: l_cmd = 8'h08;
         S_WAKE:    l_cmd = 8'h0C;
         default:   l_cmd = 8'h00;
      endcase
      l_addr = ADDR_W'((int'(sel_q) * LINES + int'(nxt_line)) * COLS + int'(nxt_col));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_WAIT_RDY;
         ph       <= P_IDLE;
         cnt      <= '0;
         init_idx <= '0;
         col      <= '0;
         line     <= '0;
         sel_q    <= '0;
         is_clr   <= 1'b0;
         rom_addr <= '0;
         rs       <= 1'b0;
         en       <= 1'b0;
         dat      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= fin_msg;
         case (ph)
            P_SETUP: if (cnt == '0) begin
               ph <= P_STROBE; en <= 1'b1; cnt <= TICK_LD;
               if (rs) dat <= rom_data;
            end else begin
               cnt <= cnt - 1'b1;
            end
            P_STROBE: if (cnt == '0) begin
               ph <= P_HOLD; en <= 1'b0; cnt <= TICK_LD;
            end else begin
               cnt <= cnt - 1'b1;
            end
            P_HOLD: if (cnt == '0) begin
               if (is_clr) begin
                  ph <= P_CWAIT; cnt <= CLR_LD;
               end else begin
                  ph <= P_IDLE;
               end
            end else begin
               cnt <= cnt - 1'b1;
            end
            P_CWAIT: if (cnt == '0) ph <= P_IDLE;
                     else           cnt <= cnt - 1'b1;
            default: ;
         endcase

         if (ev) begin
            state    <= nxt_state;
            init_idx <= nxt_idx;
            col      <= nxt_col;
            line     <= nxt_line;
            busy     <= launch;
            if (launch) begin
               ph     <= P_SETUP;
               cnt    <= TICK_LD;
               rs     <= l_rs;
               is_clr <= (nxt_state == S_CLEAR);
               if (nxt_state == S_CLEAR) sel_q <= msg_sel;
               if (l_rs) rom_addr <= l_addr;
               else      dat      <= l_cmd;
            end
         end
      end
   end

endmodule

// File: tb/tb_lcd_msg_ctrl.sv
// Randomized bench for lcd_msg_ctrl: every en pulse is recorded and compared against the
// transaction list the display protocol calls for, plus strobe width, spacing and done timing.
module tb_lcd_msg_ctrl;

   localparam int T  = 4;
   localparam int C  = 8;
   localparam int NM = 4;
   localparam int NL = 2;
   localparam int NC = 16;
   localparam int SW = 2;
   localparam int AW = 7;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          ready_i, sleep_i, refresh_i;
   logic [SW-1:0] msg_sel;
   logic [AW-1:0] rom_addr;
   logic [7:0]    rom_data = 8'h00;
   logic          rs, rw, en, busy, done;
   logic [7:0]    dat;

   always #5 clk = ~clk;

   lcd_msg_ctrl #(
      .NUM_MSG(NM), .LINES(NL), .COLS(NC), .TICK_CYCLES(T), .CLR_WAIT_CYCLES(C)
   ) dut (
      .clk(clk), .reset(reset), .ready_i(ready_i), .sleep_i(sleep_i), .msg_sel(msg_sel),
      .refresh_i(refresh_i), .rom_addr(rom_addr), .rom_data(rom_data), .rs(rs), .rw(rw),
      .en(en), .dat(dat), .busy(busy), .done(done)
   );

   logic [7:0] mem [NM*NL*NC];
   always @(posedge clk) rom_data <= mem[rom_addr];

   int          n_checks = 0;
   int          n_err    = 0;
   int          n_done   = 0;
   int          exp_done = 0;
   int          cur_sel;
   logic [16:0] obs[$];
   logic [16:0] exp_q[$];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, want, $time);
      end
   endtask

   function automatic logic [16:0] cmd(input logic [7:0] b);
      return {1'b0, b, 8'h00};
   endfunction

   function automatic logic [16:0] dwr(input int a);
      return {1'b1, mem[a], 8'(a)};
   endfunction

   task automatic push_init();
      exp_q.push_back(cmd(8'h38));
      exp_q.push_back(cmd(8'h06));
      exp_q.push_back(cmd(8'h0C));
   endtask

   task automatic push_msg(input int s);
      exp_q.push_back(cmd(8'h01));
      for (int l = 0; l < NL; l++) begin
         exp_q.push_back(cmd((l != 0) ? 8'hC0 : 8'h80));
         for (int c = 0; c < NC; c++) exp_q.push_back(dwr(s*NL*NC + l*NC + c));
      end
      exp_done++;
   endtask

   task automatic check_seq();
      chk("seq_len", obs.size(), exp_q.size());
      for (int i = 0; i < obs.size() && i < exp_q.size(); i++) chk("seq_item", obs[i], exp_q[i]);
      chk("done_count", n_done, exp_done);
      obs.delete();
      exp_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_done(input int budget);
      int start, k;
      start = n_done;
      k = 0;
      while (n_done == start && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk("done_seen", n_done - start, 1);
   endtask

   task automatic pulse_refresh();
      @(negedge clk) refresh_i = 1'b1;
      @(negedge clk) refresh_i = 1'b0;
   endtask

   // Transaction monitor, sampled on the falling edge
   initial begin
      logic en_q, done_q, have_prev, last_clr, gap_busy;
      int   hi_cnt, low_cnt;
      en_q = 0; done_q = 0; have_prev = 0; last_clr = 0; gap_busy = 1; hi_cnt = 0; low_cnt = 0;
      forever begin
         @(negedge clk);
         if (!reset) begin
            en_q = 0; done_q = 0; have_prev = 0; gap_busy = 1; hi_cnt = 0; low_cnt = 0;
            continue;
         end
         if (en && !en_q) begin
            obs.push_back({rs, dat, rs ? 8'(rom_addr) : 8'h00});
            if (have_prev && gap_busy) chk("en_gap", low_cnt, last_clr ? 2*T + C : 2*T);
            hi_cnt    = 1;
            low_cnt   = 0;
            last_clr  = !rs && (dat == 8'h01);
            have_prev = 1;
            gap_busy  = 1;
         end else if (en) begin
            hi_cnt++;
         end else begin
            if (en_q) chk("en_width", hi_cnt, T);
            low_cnt++;
            if (!busy) gap_busy = 0;
         end
         if (done) begin
            n_done++;
            chk("done_align", low_cnt, T + 1);
            chk("done_width", done_q, 0);
         end
         en_q   = en;
         done_q = done;
      end
   end

   initial begin
      int   s1, s2, mode, k, keep, nd, w;
      logic en_prev;
      for (int i = 0; i < NM*NL*NC; i++) mem[i] = 8'($urandom);
      ready_i = 0; sleep_i = 0; refresh_i = 0; msg_sel = '0;
      #1 reset = 1'b0;
      #2;
      chk("rst_en", en, 0);
      chk("rst_rs", rs, 0);
      chk("rst_rw", rw, 0);
      chk("rst_dat", dat, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", rom_addr, 0);
      idle(3);
      reset = 1'b1;
      idle(40);
      chk("no_en_before_ready", obs.size(), 0);
      chk("busy_wait_rdy", busy, 0);

      // bring-up
      cur_sel = $urandom_range(0, NM-1);
      msg_sel = SW'(cur_sel);
      ready_i = 1;
      push_init();
      push_msg(cur_sel);
      wait_done(2000);
      idle(20);
      check_seq();
      chk("busy_show", busy, 0);

      // select changes; mode 1 = second change mid-message, mode 2 = refresh mid-message
      for (int it = 0; it < 6; it++) begin
         mode = it % 3;
         s1 = (cur_sel + $urandom_range(1, NM-1)) % NM;
         @(negedge clk) msg_sel = SW'(s1);
         push_msg(s1);
         cur_sel = s1;
         idle($urandom_range(30, 400));
         if (mode == 1) begin
            s2 = (s1 + $urandom_range(1, NM-1)) % NM;
            msg_sel = SW'(s2);
            push_msg(s2);
            cur_sel = s2;
            wait_done(2000);
         end else if (mode == 2) begin
            pulse_refresh();
         end
         wait_done(2000);
         idle(60);
         check_seq();
         chk("busy_show", busy, 0);
      end

      // refresh in SHOW rewrites the same message
      pulse_refresh();
      push_msg(cur_sel);
      wait_done(2000);
      idle(60);
      check_seq();

      // sleep raised mid-message: message completes, then display off
      s1 = (cur_sel + $urandom_range(1, NM-1)) % NM;
      @(negedge clk) msg_sel = SW'(s1);
      push_msg(s1);
      idle($urandom_range(30, 400));
      sleep_i = 1;
      exp_q.push_back(cmd(8'h08));
      wait_done(2000);
      idle(200);
      check_seq();
      chk("busy_off", busy, 0);
      s2 = (s1 + $urandom_range(1, NM-1)) % NM;
      msg_sel = SW'(s2);
      idle(30);
      chk("off_quiet", obs.size(), 0);
      sleep_i = 0;
      exp_q.push_back(cmd(8'h0C));
      push_msg(s2);
      cur_sel = s2;
      wait_done(2000);
      idle(40);
      check_seq();

      // sleep wins over a simultaneous select change; refresh while off is dropped
      s1 = (cur_sel + $urandom_range(1, NM-1)) % NM;
      @(negedge clk);
      sleep_i = 1;
      msg_sel = SW'(s1);
      exp_q.push_back(cmd(8'h08));
      idle(60);
      pulse_refresh();
      idle(60);
      check_seq();
      chk("busy_off", busy, 0);
      sleep_i = 0;
      exp_q.push_back(cmd(8'h0C));
      push_msg(s1);
      cur_sel = s1;
      wait_done(2000);
      idle(40);
      check_seq();

      // reset during the strobe of the k-th data write
      k = $urandom_range(1, NL*NC);
      pulse_refresh();
      push_msg(cur_sel);
      exp_done--;
      keep = 2 + k + ((k > NC) ? 1 : 0);
      while (exp_q.size() > keep) void'(exp_q.pop_back());
      nd = 0; w = 0; en_prev = en;
      while (nd < k && w < 3000) begin
         @(negedge clk);
         w++;
         if (en && !en_prev && rs) nd++;
         en_prev = en;
      end
      chk("reached_kth_write", nd, k);
      #1 reset = 1'b0;
      ready_i = 0;
      #1;
      chk("arst_en", en, 0);
      chk("arst_rs", rs, 0);
      chk("arst_dat", dat, 0);
      chk("arst_busy", busy, 0);
      idle(3);
      reset = 1'b1;
      idle(100);
      check_seq();
      chk("busy_wait_rdy", busy, 0);
      ready_i = 1;
      push_init();
      push_msg(cur_sel);
      wait_done(2000);
      idle(40);
      check_seq();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
